// File: rtl/normalize_sched.sv
// Round-robin scheduler that hands voice sums to one shared normalize datapath
// and returns each normalized result, tagged with its voice index, on a valid/ready stream.
module normalize_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 24,
   parameter int TIMEOUT = 64
) (
   input  logic                          ACLK,
   input  logic                          ARESETN,
   input  logic                          cfg_enable,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*DATA_W-1:0]     req_sum,
   input  logic [NUM_REQ*8-1:0]          req_count,
   output logic                          nrm_start,
   output logic [DATA_W-1:0]             nrm_sum,
   output logic [7:0]                    nrm_count,
   input  logic                          nrm_done,
   input  logic [DATA_W-1:0]             nrm_result,
   output logic                          res_valid,
   input  logic                          res_ready,
   output logic [DATA_W-1:0]             res_data,
   output logic [$clog2(NUM_REQ)-1:0]    res_id,
   output logic                          err_timeout,
   output logic [15:0]                   done_cnt
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

   state_t              state_q;
   logic [ID_W-1:0]     last_grant_q;
   logic [TMO_W-1:0]    tmo_q;
   logic                nrm_start_q;
   logic [DATA_W-1:0]   nrm_sum_q;
   logic [7:0]          nrm_count_q;
   logic                res_valid_q;
   logic [DATA_W-1:0]   res_data_q;
   logic [ID_W-1:0]     res_id_q;
   logic                err_timeout_q;
   logic [15:0]         done_cnt_q;

   logic [DATA_W-1:0]   sum_arr [NUM_REQ];
   logic [7:0]          cnt_arr [NUM_REQ];
   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W:0]       cand;
   logic                accept;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign sum_arr[gi] = req_sum[gi*DATA_W +: DATA_W];
      assign cnt_arr[gi] = req_count[gi*8 +: 8];
   end

   // Search upward from the voice after the last one served, wrapping around.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = {1'b0, last_grant_q} + (ID_W+1)'(off);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   // The grant is a same-cycle handshake; held low while reset is asserted.
   assign accept = ARESETN && (state_q == IDLE) && cfg_enable && grant_found;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = accept && (grant_idx == ID_W'(gi));
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q       <= IDLE;
         last_grant_q  <= ID_W'(NUM_REQ-1);
         tmo_q         <= '0;
         nrm_start_q   <= 1'b0;
         nrm_sum_q     <= '0;
         nrm_count_q   <= '0;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         res_id_q      <= '0;
         err_timeout_q <= 1'b0;
         done_cnt_q    <= '0;
      end else begin
         nrm_start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  nrm_sum_q   <= sum_arr[grant_idx];
                  nrm_count_q <= cnt_arr[grant_idx];
                  res_id_q    <= grant_idx;
                  // A zero harmonic count has nothing to normalize: emit 0 directly.
                  if (cnt_arr[grant_idx] != 8'd0) begin
                     nrm_start_q <= 1'b1;
                     state_q     <= START;
                  end else begin
                     res_data_q  <= '0;
                     res_valid_q <= 1'b1;
                     state_q     <= OUT;
                  end
               end
            end
            START: begin
               tmo_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (nrm_done) begin
                  res_data_q  <= nrm_result;
                  res_valid_q <= 1'b1;
                  state_q     <= OUT;
               end else if (tmo_q == TMO_W'(TIMEOUT-1)) begin
                  err_timeout_q <= 1'b1;
                  last_grant_q  <= res_id_q;
                  state_q       <= IDLE;
               end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_valid_q  <= 1'b0;
                  done_cnt_q   <= done_cnt_q + 16'd1;
                  last_grant_q <= res_id_q;
                  state_q      <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign nrm_start   = nrm_start_q;
   assign nrm_sum     = nrm_sum_q;
   assign nrm_count   = nrm_count_q;
   assign res_valid   = res_valid_q;
   assign res_data    = res_data_q;
   assign res_id      = res_id_q;
   assign err_timeout = err_timeout_q;
   assign done_cnt    = done_cnt_q;

endmodule

// File: tb/tb_normalize_sched.sv
// Directed bench for normalize_sched: arbitration order, bypass, timeout, backpressure,
// enable gating and asynchronous reset, with a 3-cycle sum/count datapath stand-in.
module tb_normalize_sched;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b1;
   logic        cfg_enable = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [95:0] req_sum = '0;
   logic [31:0] req_count = '0;
   logic        nrm_start;
   logic [23:0] nrm_sum;
   logic [7:0]  nrm_count;
   logic        nrm_done = 1'b0;
   logic [23:0] nrm_result = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [23:0] res_data;
   logic [1:0]  res_id;
   logic        err_timeout;
   logic [15:0] done_cnt;

   int errors = 0;
   int checks = 0;
   bit dp_en  = 1'b0;

   logic [31:0] exp_rdy1 [5] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h1};
   logic [31:0] exp_id1  [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
   logic [31:0] exp_d1   [5] = '{32'h100, 32'h200, 32'h300, 32'h400, 32'h100};

   normalize_sched #(.NUM_REQ(4), .DATA_W(24), .TIMEOUT(64)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable),
      .req_valid(req_valid), .req_ready(req_ready), .req_sum(req_sum), .req_count(req_count),
      .nrm_start(nrm_start), .nrm_sum(nrm_sum), .nrm_count(nrm_count),
      .nrm_done(nrm_done), .nrm_result(nrm_result),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
      .err_timeout(err_timeout), .done_cnt(done_cnt)
   );

   initial forever #5 ACLK = ~ACLK;

   // Datapath stand-in: done pulse three cycles after start, result = sum / count.
   initial begin
      int cd;
      cd = 0;
      forever begin
         @(negedge ACLK);
         nrm_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               nrm_done   = 1'b1;
               nrm_result = (nrm_count != 8'd0) ? nrm_sum / 24'(nrm_count) : 24'd0;
            end
         end
         if (dp_en && nrm_start) cd = 3;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(output int n);
      n = 0;
      while (req_ready == 4'b0 && n < 200) begin
         @(negedge ACLK); #1;
         n++;
      end
   endtask

   task automatic wait_res();
      int n;
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge ACLK); #1;
         n++;
      end
      chk("res_valid_seen", 32'(res_valid), 32'h1);
   endtask

   task automatic chk_reset_vals(input string tag);
      $display("check reset values (%s)", tag);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'h0);
      chk({tag, "_nrm_start"}, 32'(nrm_start), 32'h0);
      chk({tag, "_nrm_sum"},   32'(nrm_sum),   32'h0);
      chk({tag, "_nrm_count"}, 32'(nrm_count), 32'h0);
      chk({tag, "_res_valid"}, 32'(res_valid), 32'h0);
      chk({tag, "_res_data"},  32'(res_data),  32'h0);
      chk({tag, "_res_id"},    32'(res_id),    32'h0);
      chk({tag, "_err"},       32'(err_timeout), 32'h0);
      chk({tag, "_done_cnt"},  32'(done_cnt),  32'h0);
   endtask

   initial begin
      int  n;
      bit  saw_a, saw_b;

      // Reset, with requests already pending so the grant gating is exercised.
      #3 ARESETN = 1'b0;
      @(negedge ACLK);
      cfg_enable = 1'b1;
      req_valid  = 4'hF;
      req_sum    = {24'h001000, 24'h000C00, 24'h000800, 24'h000400};
      req_count  = {8'd4, 8'd4, 8'd4, 8'd4};
      res_ready  = 1'b1;
      dp_en      = 1'b1;
      #1;
      chk_reset_vals("rst");
      @(negedge ACLK); ARESETN = 1'b1; #1;

      // Round-robin over all four voices, then wrap to voice 0.
      for (int j = 0; j < 5; j++) begin
         wait_grant(n);
         $display("job %0d: grant=%b after %0d cycles", j, req_ready, n);
         chk("t1_grant", 32'(req_ready), exp_rdy1[j]);
         if (j > 0) chk("t1_gap", 32'(n), 32'd1);
         @(negedge ACLK); #1;
         chk("t1_start", 32'(nrm_start), 32'h1);
         wait_res();
         chk("t1_id", 32'(res_id), exp_id1[j]);
         chk("t1_data", 32'(res_data), exp_d1[j]);
      end
      req_valid = 4'h0;
      @(negedge ACLK); #1;
      chk("t1_done_cnt", 32'(done_cnt), 32'd5);

      // Zero count on voice 2 bypasses the datapath.
      @(negedge ACLK);
      req_count[16 +: 8] = 8'd0;
      req_sum[48 +: 24]  = 24'h000300;
      req_valid          = 4'b0100;
      #1;
      chk("t2_grant", 32'(req_ready), 32'h4);
      @(negedge ACLK); req_valid = 4'h0; #1;
      $display("bypass: res_valid=%b res_data=%h res_id=%0d", res_valid, res_data, res_id);
      chk("t2_no_start", 32'(nrm_start), 32'h0);
      chk("t2_valid", 32'(res_valid), 32'h1);
      chk("t2_data", 32'(res_data), 32'h0);
      chk("t2_id", 32'(res_id), 32'h2);
      @(negedge ACLK); #1;
      chk("t2_no_start2", 32'(nrm_start), 32'h0);
      chk("t2_done_cnt", 32'(done_cnt), 32'd6);

      // Backpressure: result held for 10 cycles while other voices keep requesting.
      @(negedge ACLK);
      req_count[16 +: 8] = 8'd4;
      req_sum[48 +: 24]  = 24'h000C00;
      res_ready          = 1'b0;
      req_valid          = 4'hF;
      #1;
      chk("t3_grant", 32'(req_ready), 32'h8);
      @(negedge ACLK); #1;
      wait_res();
      chk("t3_id", 32'(res_id), 32'h3);
      chk("t3_data", 32'(res_data), 32'h400);
      for (int k = 0; k < 10; k++) begin
         @(negedge ACLK); #1;
         $display("hold %0d: valid=%b data=%h id=%0d ready=%b", k, res_valid, res_data, res_id, req_ready);
         chk("t3_hold_valid", 32'(res_valid), 32'h1);
         chk("t3_hold_data", 32'(res_data), 32'h400);
         chk("t3_hold_id", 32'(res_id), 32'h3);
         chk("t3_hold_noready", 32'(req_ready), 32'h0);
      end
      chk("t3_cnt_before", 32'(done_cnt), 32'd6);
      @(negedge ACLK); res_ready = 1'b1; req_valid = 4'h0; #1;
      @(negedge ACLK); #1;
      chk("t3_cnt_after", 32'(done_cnt), 32'd7);
      chk("t3_valid_low", 32'(res_valid), 32'h0);
      @(negedge ACLK); #1;
      chk("t3_cnt_stable", 32'(done_cnt), 32'd7);

      // Datapath never answers: timeout after 64 WAIT cycles.
      @(negedge ACLK); dp_en = 1'b0; req_valid = 4'hF; #1;
      chk("t4_grant", 32'(req_ready), 32'h1);
      @(negedge ACLK); req_valid = 4'h0; #1;
      chk("t4_start", 32'(nrm_start), 32'h1);
      saw_a = 1'b0;
      saw_b = 1'b0;
      repeat (64) begin
         @(negedge ACLK); #1;
         if (err_timeout) saw_a = 1'b1;
         if (res_valid)   saw_b = 1'b1;
      end
      chk("t4_err_early", 32'(saw_a), 32'h0);
      chk("t4_no_valid", 32'(saw_b), 32'h0);
      @(negedge ACLK); #1;
      $display("timeout: err_timeout=%b res_valid=%b", err_timeout, res_valid);
      chk("t4_err", 32'(err_timeout), 32'h1);
      chk("t4_valid_low", 32'(res_valid), 32'h0);
      chk("t4_cnt", 32'(done_cnt), 32'd7);
      @(negedge ACLK); dp_en = 1'b1; req_valid = 4'hF; #1;
      chk("t4_next_grant", 32'(req_ready), 32'h2);
      @(negedge ACLK); req_valid = 4'h0; #1;
      chk("t4_start2", 32'(nrm_start), 32'h1);
      wait_res();
      chk("t4_id", 32'(res_id), 32'h1);
      chk("t4_data", 32'(res_data), 32'h200);
      chk("t4_err_sticky", 32'(err_timeout), 32'h1);

      // cfg_enable dropped during WAIT: job completes, no new grants until re-enabled.
      @(negedge ACLK); req_valid = 4'hF; #1;
      chk("t5_grant", 32'(req_ready), 32'h4);
      @(negedge ACLK); #1;
      chk("t5_start", 32'(nrm_start), 32'h1);
      @(negedge ACLK); cfg_enable = 1'b0; #1;
      wait_res();
      chk("t5_id", 32'(res_id), 32'h2);
      chk("t5_data", 32'(res_data), 32'h300);
      for (int k = 0; k < 5; k++) begin
         @(negedge ACLK); #1;
         chk("t5_blocked", 32'(req_ready), 32'h0);
      end
      @(negedge ACLK); cfg_enable = 1'b1; #1;
      chk("t5_regrant", 32'(req_ready), 32'h8);
      @(negedge ACLK); req_valid = 4'h0; #1;
      wait_res();
      chk("t5_id2", 32'(res_id), 32'h3);
      chk("t5_data2", 32'(res_data), 32'h400);
      chk("t5_cnt", 32'(done_cnt), 32'd9);

      // Reset pulse during WAIT; the late nrm_done must be ignored.
      @(negedge ACLK); req_valid = 4'b0001; #1;
      chk("t6_grant", 32'(req_ready), 32'h1);
      @(negedge ACLK); req_valid = 4'h0; #1;
      chk("t6_start", 32'(nrm_start), 32'h1);
      @(negedge ACLK); #1;
      ARESETN = 1'b0;
      #1;
      chk_reset_vals("t6_rst");
      @(negedge ACLK); ARESETN = 1'b1; #1;
      saw_a = 1'b0;
      repeat (6) begin
         @(negedge ACLK); #1;
         if (res_valid || nrm_start) saw_a = 1'b1;
      end
      chk("t6_ignored", 32'(saw_a), 32'h0);
      chk("t6_cnt", 32'(done_cnt), 32'd0);
      chk("t6_err", 32'(err_timeout), 32'h0);
      @(negedge ACLK); req_valid = 4'hF; #1;
      chk("t6_grant_after", 32'(req_ready), 32'h1);
      @(negedge ACLK); req_valid = 4'h0; #1;
      wait_res();
      chk("t6_id", 32'(res_id), 32'h0);
      chk("t6_data", 32'(res_data), 32'h100);
      @(negedge ACLK); #1;
      chk("t6_cnt_after", 32'(done_cnt), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
